encoder_4_2_debounced: RTL and testbench
========================================

// Module: encoder_4_2_debounced
// PURPOSE
//  Inverse of the 2-to-4 active-low select decoder in the counter design.
//  Takes four active-low one-hot lines (buttons or select feedback) and
//  synchronises and debounces them. Encodes the single low line to a 2-bit
//  code and presents it with a valid/ack handshake. Sits between board
//  inputs and the counter control logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  stable cycles required before accepting a press or a release (min 2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived; do not override)
// PORTS
//  clk     in   1  system clock, rising edge
//  reset   in   1  asynchronous, active-high reset
//  sel_n   in   4  active-low one-hot lines; sel_n[0] low->00, [1]->01, [2]->10, [3]->11
//  ack     in   1  consumer accepts code; sampled only while valid=1
//  bcd     out  2  encoded code; stable while valid=1
//  valid   out  1  code available; held until ack
//  err     out  1  one-cycle pulse: debounced pattern had more than one line low
// BEHAVIOUR
//  Reset (async): sync regs=4'hF, state=IDLE, cnt=0, bcd=2'b00, valid=0, err=0.
//  sel_n passes through a 2-FF synchroniser (sync); the FSM sees only sync. All outputs are registered.
//  States:
//   IDLE: sync==4'hF stays. Otherwise sample<=sync, cnt<=0, go to DEBOUNCE.
//   DEBOUNCE:
//    - sync!=sample and sync==4'hF: return to IDLE (glitch).
//    - sync!=sample, other value: sample<=sync, cnt<=0.
//    - cnt==DEBOUNCE_CYCLES-1 with exactly one bit low: bcd<=index, valid<=1, go to PRESSED.
//    - cnt==DEBOUNCE_CYCLES-1 with more than one bit low: err<=1 for one cycle, go to WAIT_REL.
//    - otherwise cnt++.
//   PRESSED: valid=1, bcd frozen. On ack=1: valid<=0, cnt<=0, go to WAIT_REL.
//    A release before ack does not drop valid; the event stays latched.
//   WAIT_REL: sync!=4'hF gives cnt<=0. sync==4'hF with cnt==DEBOUNCE_CYCLES-1 goes to IDLE;
//    otherwise cnt++. No new press is reported until the release is debounced.
//  Latency: number the first edge at which sel_n is stable as edge 0.
//   valid rises after edge DEBOUNCE_CYCLES+2 (2 sync, 1 IDLE exit, DEBOUNCE_CYCLES-1 count).
//  ack with valid=0 is ignored. valid falls on the edge that samples ack=1.
//  bcd keeps its last value after valid falls.
//  Counter never wraps: it is cleared on every pattern change and saturates by state exit.
//  Reset mid-operation: immediate return to reset values; a pending valid is lost.
// STRUCTURE
//  Shared header counter_defs.vh: state encodings (IDLE, DEBOUNCE, PRESSED, WAIT_REL)
//   and SEL_IDLE=4'hF; the 2-to-4 decoder uses the same code mapping.
//  Sub-module sync_2ff (parameter WIDTH, async-reset value parameter RST_VAL),
//   reusable for other board inputs.
//  Everything else (FSM, counter, encoder, output registers) lives in this module.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset, sel_n=4'hF for 20 cycles -> valid=0, err=0, bcd=00 throughout.
//  2. Press: sel_n=4'b1011 held from edge 0 -> valid=1, bcd=2'b10 after edge 6; stays until ack.
//     Pulse ack=1 -> valid=0 next edge; release -> back to IDLE 4 cycles after sync sees 4'hF.
//  3. Bounce: sel_n toggles 4'b1110/4'hF every 2 cycles, then holds 4'b1110
//     -> exactly one valid with bcd=00, after edge 6 counted from the final hold.
//  4. Multi-hot: sel_n=4'b1100 held -> err high for exactly 1 cycle after edge 6;
//     valid stays 0; no report until release.
//  5. Release before ack: press 4'b0111, release; ack 10 cycles later -> valid held with bcd=11
//     until ack; holding press after ack gives no second valid.
//  6. Reset asserted while valid=1 -> valid=0, bcd=00 immediately (before next clk edge).

Source files
------------

// File: rtl/encoder_4_2_debounced_pkg.sv
//------------------------------------------------------------------------------
// Module  : encoder_4_2_debounced_pkg
// Brief   : State encodings, idle select pattern and encode helpers
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package encoder_4_2_debounced_pkg;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_debounce = 2'd1;
    localparam logic [1:0] c_st_pressed  = 2'd2;
    localparam logic [1:0] c_st_wait_rel = 2'd3;

    localparam logic [3:0] c_sel_idle = 4'hF;

    function automatic logic is_one_low(input logic [3:0] s);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~s[i]};
        end
        return (n == 3'd1);
    endfunction

    // Same code mapping as the 2-to-4 select decoder: line i low -> code i.
    function automatic logic [1:0] low_index(input logic [3:0] s);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!s[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_4_2_debounced_sync_2ff.sv
//------------------------------------------------------------------------------
// Module  : sync_2ff
// Brief   : Two-flop synchroniser with parameterised width and reset value
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/encoder_4_2_debounced.sv
//------------------------------------------------------------------------------
// Module  : encoder_4_2_debounced
// Brief   : Debounced active-low one-hot to 2-bit encoder with valid/ack
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module encoder_4_2_debounced
    import encoder_4_2_debounced_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sel_n,
    input  logic       ack,
    output logic [1:0] bcd,
    output logic       valid,
    output logic       err
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       w_sync;
    logic [1:0]       r_state;
    logic [3:0]       r_sample;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_bcd;
    logic             r_valid;
    logic             r_err;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (c_sel_idle)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sel_n),
        .q     (w_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_sample <= c_sel_idle;
            r_cnt    <= '0;
            r_bcd    <= 2'b00;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_sync != c_sel_idle) begin
                        r_sample <= w_sync;
                        r_cnt    <= '0;
                        r_state  <= c_st_debounce;
                    end
                end
                c_st_debounce: begin
                    if (w_sync != r_sample) begin
                        if (w_sync == c_sel_idle) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_sample <= w_sync;
                            r_cnt    <= '0;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        if (is_one_low(r_sample)) begin
                            r_bcd   <= low_index(r_sample);
                            r_valid <= 1'b1;
                            r_state <= c_st_pressed;
                        end else begin
                            // Restart the count so the release is debounced in full.
                            r_err   <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= c_st_wait_rel;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_pressed: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_st_wait_rel;
                    end
                end
                c_st_wait_rel: begin
                    if (w_sync != c_sel_idle) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bcd   = r_bcd;
    assign valid = r_valid;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_encoder_4_2_debounced.sv
//------------------------------------------------------------------------------
// Module  : tb_encoder_4_2_debounced
// Brief   : Scoreboard bench for the debounced 4-to-2 encoder
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_encoder_4_2_debounced;

    localparam int DEB = 4;

    typedef struct {
        bit       is_err;
        bit [1:0] code;
        int       cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sel_n = 4'hF;
    logic       ack = 1'b0;
    logic [1:0] bcd;
    logic       valid;
    logic       err;

    exp_t       exp_q[$];
    int         cyc = 0;
    logic       ack_q = 1'b0;
    bit         rst_evt = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_err = 1'b0;
    logic [1:0] held_bcd = 2'b00;
    int         checks = 0;
    int         passed = 0;

    encoder_4_2_debounced #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel_n (sel_n),
        .ack   (ack),
        .bcd   (bcd),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   = cyc + 1;
        ack_q = ack;
    end

    always @(posedge reset) rst_evt = 1'b1;

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act == exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line pattern applies from the next edge (edge 0); the response appears after edge 6.
    task automatic drive_expect(input logic [3:0] p, input bit is_err, input bit [1:0] code);
        exp_t e;
        sel_n    = p;
        e.is_err = is_err;
        e.code   = code;
        e.cyc    = cyc + 1 + DEB + 2;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input bit is_err, input logic [1:0] code);
        exp_t e;
        if (exp_q.size() == 0) begin
            check(is_err ? "unexpected_err" : "unexpected_valid", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(is_err), int'(e.is_err));
            check("event_cycle", cyc, e.cyc);
            if (!is_err) begin
                check("event_bcd", int'(code), int'(e.code));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (valid && !prev_valid) pop_check(1'b0, bcd);
            if (err && !prev_err) pop_check(1'b1, 2'b00);
            if (err && prev_err) check("err_pulse_width", 2, 1);
            if (valid && prev_valid) check("bcd_stable", int'(bcd), int'(held_bcd));
            if (!valid && prev_valid) check("valid_fall_on_ack", int'(ack_q || rst_evt), 1);
        end
        prev_valid = valid;
        prev_err   = err;
        held_bcd   = bcd;
        rst_evt    = 1'b0;
    end

    initial begin
        tick(3);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_bcd", int'(bcd), 0);
        reset = 1'b0;

        // Idle lines: nothing reported
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_valid", int'(valid), 0);
            check("idle_err", int'(err), 0);
            check("idle_bcd", int'(bcd), 0);
        end

        // Single press, held until ack
        drive_expect(4'b1011, 1'b0, 2'b10);
        tick(10);
        check("press_valid_held", int'(valid), 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("press_valid_after_ack", int'(valid), 0);
        check("press_bcd_kept", int'(bcd), 2);
        sel_n = 4'hF;
        tick(12);

        // Bouncing line settles on 1110
        for (int i = 0; i < 3; i++) begin
            sel_n = 4'b1110;
            tick(2);
            sel_n = 4'hF;
            tick(2);
        end
        drive_expect(4'b1110, 1'b0, 2'b00);
        tick(10);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        sel_n = 4'hF;
        tick(12);

        // Two lines low: error pulse, no valid
        drive_expect(4'b1100, 1'b1, 2'b00);
        tick(14);
        check("multihot_no_valid", int'(valid), 0);
        sel_n = 4'hF;
        tick(12);

        // Release before ack keeps the event latched
        drive_expect(4'b0111, 1'b0, 2'b11);
        tick(10);
        sel_n = 4'hF;
        tick(10);
        check("latched_valid", int'(valid), 1);
        check("latched_bcd", int'(bcd), 3);
        ack   = 1'b1;
        sel_n = 4'b0111;
        tick(1);
        ack = 1'b0;
        check("latched_valid_after_ack", int'(valid), 0);
        tick(20);
        check("held_press_no_second_valid", int'(valid), 0);
        sel_n = 4'hF;
        tick(12);

        // Asynchronous reset while valid is high
        drive_expect(4'b1101, 1'b0, 2'b01);
        tick(8);
        check("pre_reset_valid", int'(valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_bcd", int'(bcd), 0);
        check("async_rst_err", int'(err), 0);
        tick(2);
        sel_n = 4'hF;
        reset = 1'b0;
        tick(10);
        check("post_reset_valid", int'(valid), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
